// File: rtl/time_display_scan_pkg.sv
// Shared constants for the time display scanner: segment patterns and the slot enum.
// Segment order is {g,f,e,d,c,b,a}, and a 0 lights the segment.
package time_disp_pkg;

  localparam int NUM_SLOTS = 6;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [2:0] {
    SLOT_HT = 3'd0,
    SLOT_HU = 3'd1,
    SLOT_MT = 3'd2,
    SLOT_MU = 3'd3,
    SLOT_ST = 3'd4,
    SLOT_SU = 3'd5
  } slot_e;

endpackage

// File: rtl/time_display_scan_seg7.sv
// Combinational BCD digit to 7-segment pattern.
// A dash takes priority over a blank, and any code above 9 shows as a blank.
module seg7_encode
  import time_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_DIGIT[0];
        4'd1:    seg = SEG_DIGIT[1];
        4'd2:    seg = SEG_DIGIT[2];
        4'd3:    seg = SEG_DIGIT[3];
        4'd4:    seg = SEG_DIGIT[4];
        4'd5:    seg = SEG_DIGIT[5];
        4'd6:    seg = SEG_DIGIT[6];
        4'd7:    seg = SEG_DIGIT[7];
        4'd8:    seg = SEG_DIGIT[8];
        4'd9:    seg = SEG_DIGIT[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/time_display_scan.sv
// Six-digit multiplexed HH:MM:SS display driver. It scans one digit per slot and
// blanks the digit enables for one cycle at every slot change so the previous digit does not ghost.
//
// state (slot, presc) | meaning
// slot 0..5, presc==0 | ghost-blank cycle at the start of the slot: all anodes off
// slot 0..5, presc>0  | slot lit (an[slot]=0) unless the alarm blink phase hides it
module time_display_scan
  import time_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       r,
  input  logic       upd,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       hour_24,
  input  logic       a_out,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  logic [15:0] presc, presc_nxt;
  logic        presc_tc;
  slot_e       slot, slot_nxt;
  logic [7:0]  frame_cnt, frame_nxt;
  logic        blink, blink_nxt;

  logic [4:0]  snap_h, h_disp;
  logic [5:0]  snap_m, snap_s, field;
  logic        snap_ok, pm, digit_blank;
  logic [3:0]  digit;
  logic [6:0]  seg_enc;
  logic [5:0]  an_nxt;
  logic        dp_nxt;

  // The outputs are built from the next-state slot, so an, seg and dp move on the same edge as the slot index.
  always_comb begin
    presc_tc  = (presc == 16'(SCAN_DIV - 1));
    presc_nxt = presc_tc ? 16'd0 : presc + 16'd1;
    slot_nxt  = slot;
    frame_nxt = frame_cnt;
    blink_nxt = blink;
    if (presc_tc) begin
      if (slot == slot_e'(3'(NUM_SLOTS - 1))) begin
        slot_nxt = SLOT_HT;
        if (frame_cnt == 8'(BLINK_DIV - 1)) begin
          frame_nxt = 8'd0;
          blink_nxt = ~blink;
        end else begin
          frame_nxt = frame_cnt + 8'd1;
        end
      end else begin
        slot_nxt = slot_e'(3'(slot) + 3'd1);
      end
    end

    pm = (snap_h >= 5'd12);
    if (hour_24)              h_disp = snap_h;
    else if (snap_h == 5'd0)  h_disp = 5'd12;
    else if (snap_h > 5'd12)  h_disp = snap_h - 5'd12;
    else                      h_disp = snap_h;

    case (slot_nxt)
      SLOT_HT, SLOT_HU: field = {1'b0, h_disp};
      SLOT_MT, SLOT_MU: field = snap_m;
      default:          field = snap_s;
    endcase

    // Odd slots hold the units digit, even slots the tens digit.
    digit       = slot_nxt[0] ? 4'(field % 6'd10) : 4'(field / 6'd10);
    digit_blank = (slot_nxt == SLOT_HT) && !hour_24 && (digit == 4'd0);

    if ((presc_nxt == 16'd0) || (a_out && blink_nxt))
      an_nxt = 6'h3F;
    else
      an_nxt = ~(6'd1 << slot_nxt);

    dp_nxt = 1'b1;
    if (snap_ok) begin
      case (slot_nxt)
        SLOT_HU, SLOT_MU: dp_nxt = 1'b0;
        SLOT_SU:          dp_nxt = hour_24 || !pm;
        default:          dp_nxt = 1'b1;
      endcase
    end
  end

  seg7_encode u_enc (
    .digit (digit),
    .blank (digit_blank),
    .dash  (!snap_ok),
    .seg   (seg_enc)
  );

  always_ff @(posedge clk) begin
    if (r) begin
      presc     <= 16'd0;
      slot      <= SLOT_HT;
      frame_cnt <= 8'd0;
      blink     <= 1'b0;
      snap_h    <= 5'd0;
      snap_m    <= 6'd0;
      snap_s    <= 6'd0;
      snap_ok   <= 1'b1;
      an        <= 6'h3F;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      if (upd) begin
        snap_h  <= hours;
        snap_m  <= minutes;
        snap_s  <= seconds;
        snap_ok <= (hours <= 5'd23) && (minutes <= 6'd59) && (seconds <= 6'd59);
      end
      presc     <= presc_nxt;
      slot      <= slot_nxt;
      frame_cnt <= frame_nxt;
      blink     <= blink_nxt;
      an        <= an_nxt;
      seg       <= seg_enc;
      dp        <= dp_nxt;
    end
  end

endmodule

// File: doc/time_display_scan.md
TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per digit slot; legal range 2..65535.
REQ-002 Parameter BLINK_DIV, default 64: full scan frames per blink half-period; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 r  input  1  reset; synchronous, active-high.
REQ-005 upd  input  1  one-cycle strobe: time fields below are valid this cycle.
REQ-006 hours  input  5  binary hours, 0..23.
REQ-007 minutes  input  6  binary minutes, 0..59.
REQ-008 seconds  input  6  binary seconds, 0..59.
REQ-009 hour_24  input  1  1 = 24-hour display, 0 = 12-hour display.
REQ-010 a_out  input  1  alarm active; display blinks while high.
REQ-011 an  output  6  digit enables, active-low, one-hot or all-off.
REQ-012 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-013 dp  output  1  decimal point, active-low.

Function
REQ-014 Snapshot: on the cycle upd=1, hours/minutes/seconds are captured into a snapshot register; the display uses only the snapshot, never the live inputs.
REQ-015 Validity: a snapshot with hours>23, minutes>59 or seconds>59 is flagged invalid; every digit then shows a dash (seg=7'b0111111) and dp stays off.
REQ-016 hour_24 and a_out are sampled live, not through the snapshot.
REQ-017 12-hour mapping (hour_24=0): 0->12, 1..12 unchanged, 13..23->value-12; PM = snapshot hours>=12.
REQ-018 Digits: each field is split into tens and units (0..9) using registered or combinational divide-by-10; no field exceeds 2 digits.
REQ-019 Slot order: slot 0 = hour tens, 1 = hour units, 2 = minute tens, 3 = minute units, 4 = second tens, 5 = second units.
REQ-020 Leading zero: in 12-hour mode, an hour tens digit of 0 is blanked (seg=7'h7F); in 24-hour mode it shows 0.
REQ-021 Encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 dp lit (0) in slots 1 and 3 (colon); dp lit in slot 5 when 12-hour mode and PM; otherwise dp=1.
REQ-023 Prescaler: counts 0..SCAN_DIV-1 and wraps; at terminal count the slot index advances, wrapping 5->0.
REQ-024 Anti-ghost: on the first cycle of each new slot, an=6'b111111; from the second cycle on, an selects the slot (slot k drives an[k]=0).
REQ-025 seg and dp are registered and change on the same edge as the slot index.
REQ-026 Blink: a frame counter increments on each 5->0 wrap; the blink phase toggles when the counter reaches BLINK_DIV-1, and the counter then restarts at 0.
REQ-027 While a_out=1 and blink phase=1, an=6'b111111; when a_out=0, blink has no effect on the outputs but the counters keep running.
REQ-028 upd arriving mid-slot updates the snapshot immediately; the current slot's seg changes on the next cycle, and no slot is skipped or repeated.
REQ-029 Latency: a snapshot digit appears on seg within 1 cycle after its slot becomes active.

Reset
REQ-030 While r=1 (sampled): an=6'b111111, seg=7'h7F, dp=1, slot=0, prescaler=0, frame counter=0, blink phase=0, snapshot=00:00:00 valid.
REQ-031 Reset has priority over upd in the same cycle; the first lit slot after reset is slot 0, SCAN_DIV cycles of slot 0 are counted from the first cycle with r=0.

Structure
REQ-032 A shared package time_disp_pkg holds the 7-segment constants (digits 0-9, dash, blank), the slot-count constant 6, and the slot enum.
REQ-033 One sub-module, seg7_encode (combinational 4-bit digit to 7-bit pattern, with blank/dash codes), is instantiated once.
REQ-034 The implementation is a single scan FSM (slot index 0..5 plus a ghost-blank phase), not six parallel drivers.

Verification
REQ-035 Reset, then upd with 13:05:09 and hour_24=1, SCAN_DIV=4 -> slots show 1,3,0,5,0,9; dp=0 in slots 1 and 3 only.
REQ-036 Same time with hour_24=0 -> slot 0 blank, then 1,0,5,0,9; dp=0 in slots 1, 3 and 5 (PM).
REQ-037 upd with 00:00:00 and hour_24=0 -> 1,2,0,0,0,0; no PM dp in slot 5.
REQ-038 upd with hours=24 -> all six slots show 0111111 and dp=1 throughout.
REQ-039 a_out=1, BLINK_DIV=2 -> an is all-off for 2 frames, then scans for 2 frames, repeating; a_out=0 restores continuous scan.
REQ-040 Assert r mid-slot 3 -> next edge an=111111, seg=7F; after release slot 0 lit on cycle 2 and every slot-change cycle has an=111111.
